inst_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the instruction decoder and supplies its instruction word and current PC every cycle. It owns the fetch PC and issues sequential word requests to instruction memory over a request/grant, response-valid handshake. Returned words are buffered in a small prefetch FIFO. A taken branch or jump redirects the PC, flushes the stage and discards stale in-flight responses.

---
 rtl/corePckg.sv | 20 ++
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/inst_fetch.sv | 175 +++++++++++++++++
 tb/tb_inst_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/corePckg.sv
// corePckg: shared core constants and types.
//   cXLEN       - datapath / address width
//   cNop        - canonical NOP (addi x0,x0,0) shown to the decoder when idle
//   cFetchCntW  - counter width for the default prefetch depth
//   tFetchEntry - one buffered fetch result {pc, inst}
package corePckg;

  localparam int cXLEN = 32;

  localparam logic [cXLEN-1:0] cNop = 32'h0000_0013;

  localparam int cFifoDepthDef = 4;
  localparam int cFetchCntW    = $clog2(cFifoDepthDef) + 1;

  typedef struct packed {
    logic [cXLEN-1:0] pc;
    logic [cXLEN-1:0] inst;
  } tFetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO holding fetched {pc, inst} entries.
// Ports:
//   iClk, iRst     - clock (rising edge), asynchronous active-low reset
//   iPush/iPushData - write one entry (ignored when full)
//   iPop           - release the head entry (ignored when empty)
//   iFlush         - drop all entries; wins over push and pop
//   oHead          - head entry (valid when !oEmpty)
//   oCount/oEmpty/oFull - occupancy status
module fetch_fifo
  import corePckg::*;
#(
  parameter int cDepth = 4
) (
  input  logic                            iClk,
  input  logic                            iRst,
  input  logic                            iPush,
  input  logic [$bits(tFetchEntry)-1:0]   iPushData,
  input  logic                            iPop,
  input  logic                            iFlush,
  output logic [$bits(tFetchEntry)-1:0]   oHead,
  output logic [$clog2(cDepth):0]         oCount,
  output logic                            oEmpty,
  output logic                            oFull
);

  localparam int cPtrW  = $clog2(cDepth);
  localparam int cCntW  = cPtrW + 1;
  localparam int cEntW  = $bits(tFetchEntry);

  logic [cEntW-1:0] mem_r [cDepth];
  logic [cPtrW-1:0] wrPtr_r;
  logic [cPtrW-1:0] rdPtr_r;
  logic [cCntW-1:0] count_r;
  logic             pushEn_s;
  logic             popEn_s;

  assign oEmpty   = (count_r == cCntW'(0));
  assign oFull    = (count_r == cCntW'(cDepth));
  assign oCount   = count_r;
  assign oHead    = mem_r[rdPtr_r];
  assign pushEn_s = iPush && !oFull && !iFlush;
  assign popEn_s  = iPop && !oEmpty && !iFlush;

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else if (iFlush) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (pushEn_s) begin
        wrPtr_r <= wrPtr_r + cPtrW'(1);
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + cPtrW'(1);
      end
      count_r <= count_r + cCntW'(pushEn_s) - cCntW'(popEn_s);
    end
  end

  // Entry storage; data needs no reset because count_r gates visibility.
  always_ff @(posedge iClk) begin
    if (pushEn_s) begin
      mem_r[wrPtr_r] <= iPushData;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage feeding the decoder.
// Owns the fetch PC, issues sequential word requests (req/gnt, in-order
// rvalid), buffers returned words in fetch_fifo and presents one registered
// instruction per cycle. A redirect flushes the stage and drops responses of
// requests that were already in flight.
// Ports:
//   iClk, iRst               - clock, asynchronous active-low reset
//   iStall                   - hold oInst/oCurPc/oValid
//   iRedirect, iRedirectPc   - taken branch/jump and its target
//   oImemReq, oImemAddr      - fetch request and word-aligned byte address
//   iImemGnt                 - request accepted this cycle
//   iImemRvalid, iImemRdata  - in-order response
//   oInst, oCurPc, oValid    - decoder-facing instruction, its PC, valid
module inst_fetch
  import corePckg::*;
#(
  parameter int               cFifoDepth = 4,
  parameter logic [cXLEN-1:0] cResetPc   = 32'h0000_0000
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStall,
  input  logic             iRedirect,
  input  logic [cXLEN-1:0] iRedirectPc,
  output logic             oImemReq,
  output logic [cXLEN-1:0] oImemAddr,
  input  logic             iImemGnt,
  input  logic             iImemRvalid,
  input  logic [cXLEN-1:0] iImemRdata,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oValid
);

  localparam int             cCntW  = $clog2(cFifoDepth) + 1;
  localparam logic [cCntW:0] cLimit = (cCntW + 1)'(cFifoDepth);

  logic [cXLEN-1:0] fetchPc_r, fetchPcNxt_s;
  logic [cXLEN-1:0] respPc_r, respPcNxt_s;
  logic [cCntW-1:0] outstanding_r, outstandingNxt_s;
  logic [cCntW-1:0] dropCnt_r, dropCntNxt_s;
  logic [cXLEN-1:0] inst_r, instNxt_s;
  logic [cXLEN-1:0] curPc_r, curPcNxt_s;
  logic             valid_r, validNxt_s;

  logic [cXLEN-1:0] target_s;
  logic [cCntW:0]   creditSum_s;
  logic             grant_s;
  logic             respDrop_s;
  logic             push_s;
  logic             pop_s;
  logic             outUpd_s;

  tFetchEntry       pushEntry_s;
  tFetchEntry       headEntry_s;
  logic [cCntW-1:0] fifoCount_s;
  logic             fifoEmpty_s;
  logic             fifoFull_s;

  assign target_s    = iRedirectPc & ~cXLEN'(3);
  // In-flight requests plus buffered words may never exceed the FIFO size,
  // so every response always has a slot.
  assign creditSum_s = {1'b0, outstanding_r} + {1'b0, fifoCount_s};
  assign oImemReq    = iRst && !iRedirect && (creditSum_s < cLimit);
  assign oImemAddr   = fetchPc_r;
  assign grant_s     = oImemReq && iImemGnt;
  assign respDrop_s  = iImemRvalid && (dropCnt_r != cCntW'(0));
  assign push_s      = iImemRvalid && (dropCnt_r == cCntW'(0)) && !iRedirect && !fifoFull_s;
  assign outUpd_s    = !iStall || !valid_r;
  assign pop_s       = !iRedirect && outUpd_s && !fifoEmpty_s;
  assign pushEntry_s = '{pc: respPc_r, inst: iImemRdata};

  assign oInst  = inst_r;
  assign oCurPc = curPc_r;
  assign oValid = valid_r;

  fetch_fifo #(
    .cDepth (cFifoDepth)
  ) uFifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .iPush     (push_s),
    .iPushData (pushEntry_s),
    .iPop      (pop_s),
    .iFlush    (iRedirect),
    .oHead     (headEntry_s),
    .oCount    (fifoCount_s),
    .oEmpty    (fifoEmpty_s),
    .oFull     (fifoFull_s)
  );

  // Next-state for fetch/response PCs and the in-flight / drop counters.
  always_comb begin
    fetchPcNxt_s     = fetchPc_r;
    respPcNxt_s      = respPc_r;
    outstandingNxt_s = outstanding_r;
    dropCntNxt_s     = dropCnt_r;
    if (iRedirect) begin
      fetchPcNxt_s     = target_s;
      respPcNxt_s      = target_s;
      // A response arriving in the redirect cycle is dropped right here,
      // every other in-flight one later via dropCnt.
      outstandingNxt_s = outstanding_r - cCntW'(iImemRvalid);
      dropCntNxt_s     = outstanding_r - cCntW'(iImemRvalid);
    end else begin
      outstandingNxt_s = outstanding_r + cCntW'(grant_s) - cCntW'(iImemRvalid);
      if (grant_s) begin
        fetchPcNxt_s = fetchPc_r + cXLEN'(4);
      end else begin
        fetchPcNxt_s = fetchPc_r;
      end
      if (respDrop_s) begin
        dropCntNxt_s = dropCnt_r - cCntW'(1);
      end else begin
        dropCntNxt_s = dropCnt_r;
      end
      if (push_s) begin
        respPcNxt_s = respPc_r + cXLEN'(4);
      end else begin
        respPcNxt_s = respPc_r;
      end
    end
  end

  // Next-state for the decoder-facing output register.
  always_comb begin
    validNxt_s = valid_r;
    instNxt_s  = inst_r;
    curPcNxt_s = curPc_r;
    if (iRedirect) begin
      validNxt_s = 1'b0;
      instNxt_s  = cNop;
    end else if (outUpd_s) begin
      if (!fifoEmpty_s) begin
        validNxt_s = 1'b1;
        instNxt_s  = headEntry_s.inst;
        curPcNxt_s = headEntry_s.pc;
      end else begin
        validNxt_s = 1'b0;
        instNxt_s  = cNop;
      end
    end else begin
      validNxt_s = valid_r;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      fetchPc_r     <= cResetPc;
      respPc_r      <= cResetPc;
      outstanding_r <= '0;
      dropCnt_r     <= '0;
    end else begin
      fetchPc_r     <= fetchPcNxt_s;
      respPc_r      <= respPcNxt_s;
      outstanding_r <= outstandingNxt_s;
      dropCnt_r     <= dropCntNxt_s;
    end
  end

  // Output register presented to the decoder.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      valid_r <= 1'b0;
      inst_r  <= cNop;
      curPc_r <= '0;
    end else begin
      valid_r <= validNxt_s;
      inst_r  <= instNxt_s;
      curPc_r <= curPcNxt_s;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized bench for inst_fetch with a transaction-level
// reference model (queues of in-flight requests and buffered words).
module tb_inst_fetch;
  import corePckg::*;

  localparam logic [31:0] cKey   = 32'hA5A5_0000;
  localparam int          cDepth = 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic        iStall = 1'b0;
  logic        iRedirect = 1'b0;
  logic [31:0] iRedirectPc = 32'd0;
  logic        oImemReq;
  logic [31:0] oImemAddr;
  logic        iImemGnt = 1'b0;
  logic        iImemRvalid = 1'b0;
  logic [31:0] iImemRdata = 32'd0;
  logic [31:0] oInst;
  logic [31:0] oCurPc;
  logic        oValid;

  inst_fetch #(.cFifoDepth(cDepth), .cResetPc(32'h0000_0000)) dut (
    .iClk(iClk), .iRst(iRst), .iStall(iStall), .iRedirect(iRedirect),
    .iRedirectPc(iRedirectPc), .oImemReq(oImemReq), .oImemAddr(oImemAddr),
    .iImemGnt(iImemGnt), .iImemRvalid(iImemRvalid), .iImemRdata(iImemRdata),
    .oInst(oInst), .oCurPc(oCurPc), .oValid(oValid)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] addr; int due; bit stale; } tPend;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } tEnt;

  tPend        pend[$];   // requests granted, response not yet returned
  tEnt         fifoQ[$];  // words returned and not yet shown to the decoder
  logic        mValid;
  logic [31:0] mInst;
  logic [31:0] mPc;
  logic [31:0] mFetch;
  int          memLat;
  int          lastDue;
  int          cyc;
  int          errors;
  int          checks;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    pend.delete();
    fifoQ.delete();
    mValid  = 1'b0;
    mInst   = cNop;
    mPc     = 32'd0;
    mFetch  = 32'h0000_0000;
    lastDue = 0;
  endtask

  // One clock cycle; called at a negedge, returns at the next negedge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic gn);
    logic rv;
    logic mReq;
    tPend hd;
    tPend np;
    int   due;
    iStall      = st;
    iRedirect   = rd;
    iRedirectPc = rpc;
    iImemGnt    = gn;
    rv          = (pend.size() > 0) && (pend[0].due <= cyc);
    iImemRvalid = rv;
    iImemRdata  = rv ? (pend[0].addr ^ cKey) : 32'($urandom);
    mReq        = !rd && ((pend.size() + fifoQ.size()) < cDepth);
    #1;
    checkVal("imemReq", oImemReq, mReq);
    checkVal("imemAddr", oImemAddr, mFetch);
    checkVal("valid", oValid, mValid);
    checkVal("inst", oInst, mInst);
    if (mValid) checkVal("curPc", oCurPc, mPc);
    @(posedge iClk);
    hd = '{addr: 32'd0, due: 0, stale: 1'b1};
    if (rv) hd = pend.pop_front();
    if (rd) begin
      foreach (pend[i]) pend[i].stale = 1'b1;
      fifoQ.delete();
      mValid = 1'b0;
      mInst  = cNop;
      mFetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if (!st || !mValid) begin
        if (fifoQ.size() > 0) begin
          tEnt e;
          e = fifoQ.pop_front();
          mValid = 1'b1;
          mInst  = e.inst;
          mPc    = e.pc;
        end else begin
          mValid = 1'b0;
          mInst  = cNop;
        end
      end
      if (rv && !hd.stale) fifoQ.push_back('{pc: hd.addr, inst: hd.addr ^ cKey});
      if (mReq && gn) begin
        due = cyc + memLat;
        if (due <= lastDue) due = lastDue + 1;
        lastDue = due;
        np = '{addr: mFetch, due: due, stale: 1'b0};
        pend.push_back(np);
        mFetch = mFetch + 32'd4;
      end
    end
    @(negedge iClk);
    cyc++;
  endtask

  // Asynchronous reset in the middle of a cycle, checked before any edge.
  task automatic doReset();
    #2 iRst = 1'b0;
    #1;
    checkVal("rstValid", oValid, 32'd0);
    checkVal("rstInst", oInst, cNop);
    checkVal("rstReq", oImemReq, 32'd0);
    iStall = 1'b0; iRedirect = 1'b0; iImemGnt = 1'b0; iImemRvalid = 1'b0;
    modelReset();
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    iRst = 1'b1;
  endtask

  initial begin
    bit found;
    errors = 0; checks = 0; cyc = 0; memLat = 1;
    modelReset();
    repeat (2) @(negedge iClk);
    #1;
    checkVal("rstValid0", oValid, 32'd0);
    checkVal("rstInst0", oInst, cNop);
    checkVal("rstPc0", oCurPc, 32'd0);
    checkVal("rstReq0", oImemReq, 32'd0);
    @(negedge iClk);
    iRst = 1'b1;

    // Streaming from reset with a 1-cycle memory until PC 8 is shown.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 32'd0, 1'b1);
      found = mValid && (mPc == 32'd8);
    end
    checkVal("reachPc8", {31'd0, found}, 32'd1);
    // Long stall freezes PC 8 and exhausts credit; then resume.
    repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect with three requests in flight on a 3-cycle memory.
    memLat = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (pend.size() == 3) found = 1'b1;
      else step(1'b0, 1'b0, 32'd0, 1'b1);
    end
    checkVal("inflight3", {31'd0, found}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Redirect + stall while a response returns in the same cycle.
    memLat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else step(1'b0, 1'b0, 32'd0, 1'b1);
    end
    checkVal("rvalidNow", {31'd0, found}, 32'd1);
    step(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Unaligned target near the top of the address space wraps to 0.
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1);
    repeat (12) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Reset with two words buffered, then restart from the reset PC.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (fifoQ.size() == 2) found = 1'b1;
      else step(1'b1, 1'b0, 32'd0, 1'b1);
    end
    checkVal("buffered2", {31'd0, found}, 32'd1);
    doReset();
    repeat (10) step(1'b0, 1'b0, 32'd0, 1'b1);

    // Random traffic: latency, grants, stalls and redirects all vary.
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) memLat = $urandom_range(1, 4);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3,
           32'($urandom), $urandom_range(0, 99) < 75);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
